// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: round-robin byte-stream arbiter with minimum-frame zero padding and inter-frame gap
module mac_tx_arbiter #(
  parameter int CH_NUM = 4,
  parameter int MIN_FRAME = 60,
  parameter int IFG_CYCLES = 12,
  localparam int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1,
  localparam int BW = $clog2(MIN_FRAME + 1),
  localparam int GW = IFG_CYCLES > 0 ? $clog2(IFG_CYCLES + 1) : 1
) (
  input  logic                logic_clk,
  input  logic                logic_rst,
  input  logic [CH_NUM*8-1:0] ch_tdata_in,
  input  logic [CH_NUM-1:0]   ch_tvalid_in,
  output logic [CH_NUM-1:0]   ch_tready_out,
  input  logic [CH_NUM-1:0]   ch_tlast_in,
  output logic [7:0]          mac_tdata_out,
  output logic                mac_tvalid_out,
  input  logic                mac_tready_in,
  output logic                mac_tlast_out,
  output logic [CW-1:0]       mac_tch_out,
  output logic                arb_busy_out
);
  typedef enum logic [1:0] {IDLE, PASS, PAD, GAP} state_t;
  state_t state, state_n, end_state;
  logic [CW-1:0] rr_ptr, rr_n, grant_n, pick;
  logic [BW-1:0] byte_cnt, cnt_n, cnt_inc;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [CH_NUM-1:0] sel;
  logic [7:0] src_data;
  logic src_valid, src_last, full, pad_last, done, found;
  int d, best;
  assign end_state = IFG_CYCLES == 0 ? IDLE : GAP;
  always_comb begin
    best = CH_NUM;
    d = 0;
    pick = rr_ptr;
    sel = '0;
    src_data = '0;
    src_valid = 1'b0;
    src_last = 1'b0;
    for (int j = 0; j < CH_NUM; j++) begin
      d = (j - int'(rr_ptr) - 1 + 2 * CH_NUM) % CH_NUM;
      if (ch_tvalid_in[j] && d < best) begin
        best = d;
        pick = CW'(j);
      end
      if (int'(mac_tch_out) == j) begin
        sel[j] = 1'b1;
        src_data = ch_tdata_in[j*8 +: 8];
        src_valid = ch_tvalid_in[j];
        src_last = ch_tlast_in[j];
      end
    end
    found = best < CH_NUM;
  end
  always_comb begin
    state_n = state;
    grant_n = mac_tch_out;
    rr_n = rr_ptr;
    cnt_n = byte_cnt;
    gap_n = gap_cnt;
    mac_tdata_out = '0;
    mac_tvalid_out = 1'b0;
    mac_tlast_out = 1'b0;
    ch_tready_out = '0;
    done = 1'b0;
    full = int'(byte_cnt) + 1 >= MIN_FRAME;
    pad_last = int'(byte_cnt) == MIN_FRAME - 1;
    cnt_inc = int'(byte_cnt) == MIN_FRAME ? byte_cnt : byte_cnt + 1'b1;
    case (state)
      IDLE: begin
        grant_n = found ? pick : mac_tch_out;
        state_n = found ? PASS : IDLE;
      end
      PASS: begin
        mac_tdata_out = src_data;
        mac_tvalid_out = src_valid;
        mac_tlast_out = src_last && full;
        ch_tready_out = mac_tready_in ? sel : '0;
        if (src_valid && mac_tready_in) begin
          cnt_n = cnt_inc;
          done = src_last && full;
          state_n = !src_last ? PASS : full ? end_state : PAD;
        end
      end
      PAD: begin
        mac_tvalid_out = 1'b1;
        mac_tlast_out = pad_last;
        if (mac_tready_in) begin
          cnt_n = cnt_inc;
          done = pad_last;
          state_n = pad_last ? end_state : PAD;
        end
      end
      default: begin
        state_n = int'(gap_cnt) >= IFG_CYCLES - 1 ? IDLE : GAP;
        gap_n = int'(gap_cnt) >= IFG_CYCLES - 1 ? '0 : gap_cnt + 1'b1;
      end
    endcase
    if (done) begin
      rr_n = mac_tch_out;
      cnt_n = '0;
      gap_n = '0;
    end
  end
  always_ff @(posedge logic_clk or negedge logic_rst) begin
    if (!logic_rst) begin
      state <= IDLE;
      mac_tch_out <= '0;
      rr_ptr <= CW'(CH_NUM - 1);
      byte_cnt <= '0;
      gap_cnt <= '0;
      arb_busy_out <= 1'b0;
    end else begin
      state <= state_n;
      mac_tch_out <= grant_n;
      rr_ptr <= rr_n;
      byte_cnt <= cnt_n;
      gap_cnt <= gap_n;
      arb_busy_out <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: scoreboard bench for round-robin, padding, gap, backpressure and reset behaviour
module tb_mac_tx_arbiter;
  localparam int CH = 4, MIN = 60, IFG = 12;
  typedef struct {int ch; logic [7:0] data; logic last; logic pad; int gap;} item_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [CH*8-1:0] ch_tdata_in;
  logic [CH-1:0] ch_tvalid_in, ch_tready_out, ch_tlast_in;
  logic [7:0] mac_tdata_out;
  logic mac_tvalid_out, mac_tready_in, mac_tlast_out, arb_busy_out;
  logic [1:0] mac_tch_out;
  logic [7:0] u1_data, u1_mdata;
  logic u1_valid, u1_ready, u1_last, u1_mvalid, u1_mready, u1_mlast, u1_tch, u1_busy;
  int checks = 0, errors = 0, cyc = 0, last_t = 0;
  bit bp = 1'b0, await_first = 1'b0;
  item_t exp_q[$];
  item_t it;
  logic [8:0] chq [CH][$];
  logic [CH-1:0] fire;
  mac_tx_arbiter #(.CH_NUM(CH), .MIN_FRAME(MIN), .IFG_CYCLES(IFG)) dut (
    .logic_clk(clk), .logic_rst(rst_n), .ch_tdata_in(ch_tdata_in), .ch_tvalid_in(ch_tvalid_in),
    .ch_tready_out(ch_tready_out), .ch_tlast_in(ch_tlast_in), .mac_tdata_out(mac_tdata_out),
    .mac_tvalid_out(mac_tvalid_out), .mac_tready_in(mac_tready_in), .mac_tlast_out(mac_tlast_out),
    .mac_tch_out(mac_tch_out), .arb_busy_out(arb_busy_out));
  mac_tx_arbiter #(.CH_NUM(1), .MIN_FRAME(4), .IFG_CYCLES(0)) dut1 (
    .logic_clk(clk), .logic_rst(rst_n), .ch_tdata_in(u1_data), .ch_tvalid_in(u1_valid),
    .ch_tready_out(u1_ready), .ch_tlast_in(u1_last), .mac_tdata_out(u1_mdata),
    .mac_tvalid_out(u1_mvalid), .mac_tready_in(u1_mready), .mac_tlast_out(u1_mlast),
    .mac_tch_out(u1_tch), .arb_busy_out(u1_busy));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask
  task automatic send_frame(input int ch, input int len, input int gap, input int seed);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'(seed + i * 7);
      chq[ch].push_back({i == len - 1, b});
      exp_q.push_back('{ch, b, (i == len - 1) && len >= MIN, 1'b0, i == 0 ? gap : -1});
    end
    for (int i = len; i < MIN; i++) exp_q.push_back('{ch, 8'h00, i == MIN - 1, 1'b1, -1});
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic u1_drive(input int si);
    logic [7:0] s1 [7] = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    u1_valid = si < 7;
    u1_data = si < 7 ? s1[si] : 8'h00;
    u1_last = si == 1 || si == 6;
  endtask
  initial begin
    ch_tvalid_in = '0;
    ch_tdata_in = '0;
    ch_tlast_in = '0;
    mac_tready_in = 1'b1;
    forever begin
      @(negedge clk);
      fire = ch_tvalid_in & ch_tready_out;
      @(posedge clk);
      #1;
      for (int k = 0; k < CH; k++) begin
        if (fire[k] && chq[k].size() > 0) void'(chq[k].pop_front());
        ch_tvalid_in[k] = chq[k].size() > 0;
        ch_tdata_in[k*8 +: 8] = chq[k].size() > 0 ? chq[k][0][7:0] : 8'h00;
        ch_tlast_in[k] = chq[k].size() > 0 ? chq[k][0][8] : 1'b0;
      end
      mac_tready_in = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && mac_tvalid_out) begin
        if (await_first) begin
          await_first = 1'b0;
          if (exp_q.size() > 0 && exp_q[0].gap >= 0) chk("frame_gap", cyc - last_t, exp_q[0].gap);
        end
        if (mac_tready_in) begin
          if (exp_q.size() == 0) chk("unexpected_byte", {mac_tch_out, mac_tlast_out, mac_tdata_out}, 32'hFFFF);
          else begin
            it = exp_q.pop_front();
            chk("byte_ch_last_data", {mac_tch_out, mac_tlast_out, mac_tdata_out}, {2'(it.ch), it.last, it.data});
            if (it.pad) chk("pad_ready", ch_tready_out, 0);
            if (mac_tlast_out) begin
              await_first = 1'b1;
              last_t = cyc;
            end
          end
        end
      end
    end
  end
  initial begin
    logic [9:0] e1 [12] = '{10'h000, 10'h2A1, 10'h2A2, 10'h200, 10'h300, 10'h000,
                            10'h2B1, 10'h2B2, 10'h2B3, 10'h2B4, 10'h3B5, 10'h000};
    int n, si;
    logic f;
    u1_mready = 1'b1;
    u1_drive(7);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", mac_tvalid_out, 0);
    chk("rst_tlast", mac_tlast_out, 0);
    chk("rst_tdata", mac_tdata_out, 0);
    chk("rst_tready", ch_tready_out, 0);
    chk("rst_tch", mac_tch_out, 0);
    chk("rst_busy", arb_busy_out, 0);
    send_frame(0, 64, -1, 'h10);
    send_frame(1, 64, IFG + 2, 'h20);
    send_frame(2, 64, IFG + 2, 'h30);
    send_frame(3, 64, IFG + 2, 'h40);
    send_frame(0, 64, IFG + 2, 'h50);
    drain();
    send_frame(2, 10, -1, 'h61);
    drain();
    send_frame(3, 1500, -1, 'h01);
    send_frame(1, 60, IFG + 2, 'h33);
    drain();
    send_frame(0, 20, -1, 'h44);
    send_frame(0, 20, IFG + 2, 'h55);
    drain();
    bp = 1'b1;
    send_frame(2, 10, -1, 'h66);
    send_frame(0, 70, IFG + 2, 'h77);
    drain();
    bp = 1'b0;
    send_frame(1, 100, -1, 'h88);
    n = 0;
    while (exp_q.size() > 80 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_frame_reached", exp_q.size() <= 80, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", mac_tvalid_out, 0);
    chk("async_rst_tready", ch_tready_out, 0);
    chk("async_rst_busy", arb_busy_out, 0);
    exp_q.delete();
    for (int k = 0; k < CH; k++) chq[k].delete();
    await_first = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    si = 0;
    u1_drive(si);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("single_ch_cycle%0d", c), {u1_tch, u1_mvalid, u1_mlast, u1_mdata}, {1'b0, e1[c]});
      f = u1_valid & u1_ready;
      @(posedge clk);
      #1;
      if (f) si++;
      u1_drive(si);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
